// File: rtl/turbo_pkg.sv
// turbo_pkg: shared defaults and bank state encoding for the turbo frame loader.
package turbo_pkg;
  localparam int DEF_DATA_W    = 48;
  localparam int DEF_FRAME_LEN = 263;
  localparam int DEF_ADDR_W    = 9;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DECODING} bank_state_t;
endpackage

// File: rtl/loader_bank.sv
// loader_bank: FRAME_LEN x DATA_W distributed RAM with synchronous write and registered read.
module loader_bank
  import turbo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [FRAME_LEN];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) o_rdata <= '0;
    else o_rdata <= r_mem[i_raddr];
endmodule

// File: rtl/turbo_frame_loader.sv
// turbo_frame_loader: frame buffer between the receive stream and turbo_top, one dec_rst pulse per frame.
// TURBO_LOADER_PINGPONG_EN builds two banks; left undefined, a single bank is used.
module turbo_frame_loader
  import turbo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  output logic              dec_rst,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic [DATA_W-1:0] dec_data,
  input  logic              dec_done,
  output logic              err_short
);
`ifdef TURBO_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  bank_state_t       r_state [2];
  bank_state_t       w_state_n [2];
  logic              r_wr_sel, r_rd_sel, r_live, r_hand_q, r_dec_rst, r_err;
  logic              w_wr_sel_n, w_rd_sel_n, w_acc, w_we, w_hand, w_hsel, w_done, w_err;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_n, w_waddr;
  logic [DATA_W-1:0] w_rdata [NB];
  assign in_ready  = r_live && (r_state[r_wr_sel] == EMPTY || r_state[r_wr_sel] == FILLING);
  assign w_acc     = in_valid && in_ready;
  assign w_hsel    = r_state[0] != FULL;
  assign w_hand    = (r_state[0] == FULL || r_state[1] == FULL) &&
                     r_state[0] != DECODING && r_state[1] != DECODING;
  assign w_done    = dec_done && r_state[r_rd_sel] == DECODING;
  assign dec_rst   = r_dec_rst;
  assign err_short = r_err;
  always_comb begin
    w_state_n   = r_state;
    w_wr_addr_n = r_wr_addr;
    w_waddr     = r_wr_addr;
    w_we        = 1'b0;
    w_err       = 1'b0;
    w_rd_sel_n  = r_rd_sel;
    if (w_acc && in_sof) begin
      w_err               = r_state[r_wr_sel] == FILLING && r_wr_addr != '0;
      w_state_n[r_wr_sel] = FILLING;
      w_waddr             = '0;
      w_we                = 1'b1;
      w_wr_addr_n         = ADDR_W'(1);
    end else if (w_acc && r_state[r_wr_sel] == FILLING) begin
      w_we                = 1'b1;
      w_state_n[r_wr_sel] = r_wr_addr == ADDR_W'(FRAME_LEN-1) ? FULL : FILLING;
      w_wr_addr_n         = r_wr_addr == ADDR_W'(FRAME_LEN-1) ? '0 : r_wr_addr + 1'b1;
    end
    if (w_done) w_state_n[r_rd_sel] = EMPTY;
    if (w_hand) begin
      w_state_n[w_hsel] = DECODING;
      w_rd_sel_n        = w_hsel;
    end
    // the writer moves to the other bank as soon as it is free and its own bank is closed
    w_wr_sel_n = (NB == 2) && (w_state_n[r_wr_sel] == FULL || w_state_n[r_wr_sel] == DECODING) &&
                 w_state_n[!r_wr_sel] == EMPTY ? !r_wr_sel : r_wr_sel;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= '{EMPTY, EMPTY};
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_wr_addr <= '0;
      r_live    <= 1'b0;
      r_hand_q  <= 1'b0;
      r_dec_rst <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_wr_sel  <= w_wr_sel_n;
      r_rd_sel  <= w_rd_sel_n;
      r_wr_addr <= w_wr_addr_n;
      r_live    <= 1'b1;
      r_hand_q  <= w_hand;
      r_dec_rst <= !w_hand && (r_dec_rst || r_hand_q);
      r_err     <= w_err;
    end
  for (genvar b = 0; b < NB; b++) begin : g_bank
    loader_bank #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we && r_wr_sel == 1'(b)),
      .i_waddr (w_waddr),
      .i_wdata (in_data),
      .i_raddr (dec_addr),
      .o_rdata (w_rdata[b])
    );
  end
`ifdef TURBO_LOADER_PINGPONG_EN
  logic r_rd_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_rd_q <= 1'b0;
    else r_rd_q <= r_rd_sel;
  assign dec_data = w_rdata[r_rd_q];
`else
  assign dec_data = w_rdata[0];
`endif
endmodule

// File: tb/tb_turbo_frame_loader.sv
// tb_turbo_frame_loader: directed frame scenarios plus randomized traffic against a behavioural model.
module tb_turbo_frame_loader;
  import turbo_pkg::*;
  localparam int DATA_W = DEF_DATA_W, FRAME_LEN = DEF_FRAME_LEN, ADDR_W = DEF_ADDR_W;
`ifdef TURBO_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int E = 0, FI = 1, FU = 2, D = 3;

  logic clk = 1'b0, rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_valid = 1'b0, in_sof = 1'b0, dec_done = 1'b0;
  logic [ADDR_W-1:0] dec_addr = '0;
  logic in_ready, dec_rst, err_short;
  logic [DATA_W-1:0] dec_data;
  int n_chk = 0, n_fail = 0;

  turbo_frame_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .dec_rst(dec_rst), .dec_addr(dec_addr), .dec_data(dec_data),
    .dec_done(dec_done), .err_short(err_short)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // behavioural model: bank states, contents and expected outputs
  int st [2] = '{E, E};
  int wsel = 0, rsel = 0, waddr = 0;
  bit live = 0, handed = 0, m_drst = 0, m_err = 0, m_ok = 1;
  logic [DATA_W-1:0] m_data = '0;
  logic [DATA_W-1:0] mm [2][FRAME_LEN];
  bit mv [2][FRAME_LEN];

  function automatic bit m_ready();
    return live && st[wsel] <= FI;
  endfunction

  task automatic model_step();
    bit rdy, done;
    int hb;
    if (!rst) begin
      st = '{E, E}; wsel = 0; rsel = 0; waddr = 0;
      live = 0; handed = 0; m_drst = 0; m_err = 0; m_data = '0; m_ok = 1;
      foreach (mv[b, a]) mv[b][a] = 0;
      return;
    end
    rdy  = m_ready();
    done = dec_done && st[rsel] == D;
    hb   = -1;
    if (st[0] != D && st[1] != D)
      for (int k = NB - 1; k >= 0; k--) if (st[k] == FU) hb = k;
    m_ok = int'(dec_addr) < FRAME_LEN && mv[rsel][dec_addr];
    if (m_ok) m_data = mm[rsel][dec_addr];
    m_err = 0;
    if (rdy && in_valid && in_sof) begin
      m_err = st[wsel] == FI && waddr != 0;
      mm[wsel][0] = in_data; mv[wsel][0] = 1; st[wsel] = FI; waddr = 1;
    end else if (rdy && in_valid && st[wsel] == FI) begin
      mm[wsel][waddr] = in_data; mv[wsel][waddr] = 1;
      waddr = (waddr + 1) % FRAME_LEN;
      if (waddr == 0) st[wsel] = FU;
    end
    if (done) st[rsel] = E;
    m_drst = hb < 0 && handed;
    if (hb >= 0) begin st[hb] = D; rsel = hb; handed = 1; end
    if (NB == 2 && st[wsel] >= FU && st[1 - wsel] == E) wsel = 1 - wsel;
    live = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("in_ready", in_ready, m_ready());
    check("dec_rst", dec_rst, m_drst);
    check("err_short", err_short, m_err);
    if (m_ok) check("dec_data", dec_data, m_data);
  end

  task automatic push(input logic [DATA_W-1:0] d, input bit sof);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_sof = sof;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) check("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic push_range(input int base, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push(DATA_W'(base + i), i == 0);
  endtask

  task automatic pulse_done();
    dec_done = 1'b1; @(negedge clk); dec_done = 1'b0;
  endtask

  task automatic rd(input string nm, input int a, input logic [DATA_W-1:0] e);
    dec_addr = ADDR_W'(a); @(negedge clk); check(nm, dec_data, e);
  endtask

  task automatic hand_chk(input string nm);
    check({nm, "_pre"}, dec_rst, 1);
    @(negedge clk); check({nm, "_low"}, dec_rst, 0);
    @(negedge clk); check({nm, "_high"}, dec_rst, 1);
  endtask

  typedef struct { int addr; logic [DATA_W-1:0] exp; } rd_vec_t;
  rd_vec_t tbl [5];

  initial begin
    tbl[0] = '{0, 0}; tbl[1] = '{131, 131}; tbl[2] = '{262, 262}; tbl[3] = '{1, 1}; tbl[4] = '{200, 200};
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_dec_rst", dec_rst, 0);
    check("rst_dec_data", dec_data, 0);
    check("rst_err_short", err_short, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("live_in_ready", in_ready, 1);
    // first frame: word i = i
    push_range(0, 0, FRAME_LEN - 1);
    @(negedge clk); check("f1_dec_rst_low", dec_rst, 0);
    @(negedge clk); check("f1_dec_rst_high", dec_rst, 1);
    for (int i = 0; i < 5; i++) rd($sformatf("f1_rd%0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);
    // second frame
`ifdef TURBO_LOADER_PINGPONG_EN
    push_range(1000, 0, FRAME_LEN - 1);
    check("f2_blocked", in_ready, 0);
    pulse_done();
    check("f2_resume", in_ready, 1);
    hand_chk("f2_hand");
`else
    check("f1_blocked", in_ready, 0);
    pulse_done();
    check("f1_freed", in_ready, 1);
    push_range(1000, 0, FRAME_LEN - 1);
    hand_chk("f2_hand");
`endif
    rd("f2_rd5", 5, 1005);
    // early sof at word 100
    pulse_done();
    push_range(2000, 0, 99);
    push(3000, 1'b1);
    check("short_pulse", err_short, 1);
    push(3001, 1'b0);
    check("short_once", err_short, 0);
    push_range(3000, 2, FRAME_LEN - 1);
    hand_chk("short_hand");
    rd("short_rd0", 0, 3000);
    rd("short_rd99", 99, 3099);
    rd("short_rd262", 262, 3262);
    // frame completion coinciding with dec_done
`ifdef TURBO_LOADER_PINGPONG_EN
    push_range(4000, 0, FRAME_LEN - 2);
    dec_done = 1'b1;
    push(4000 + FRAME_LEN - 1, 1'b0);
    dec_done = 1'b0;
`else
    pulse_done();
    push_range(4000, 0, FRAME_LEN - 1);
`endif
    hand_chk("sim_hand");
    rd("sim_rd7", 7, 4007);
    // asynchronous reset mid-frame
    pulse_done();
    push_range(5000, 0, 49);
    #2 rst = 1'b0;
    #1 check("arst_in_ready", in_ready, 0);
    check("arst_dec_rst", dec_rst, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    push_range(6000, 0, FRAME_LEN - 1);
    check("rf_dec_rst_held", dec_rst, 0);
    @(negedge clk); check("rf_dec_rst_low", dec_rst, 0);
    @(negedge clk); check("rf_dec_rst_high", dec_rst, 1);
    rd("rf_rd100", 100, 6100);
    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 6000; c++) begin
      in_valid = $urandom_range(0, 9) < 8;
      in_sof   = st[wsel] == E ? $urandom_range(0, 3) == 0 : $urandom_range(0, 599) == 0;
      in_data  = DATA_W'({$urandom, $urandom});
      dec_done = $urandom_range(0, 99) == 0;
      dec_addr = ADDR_W'($urandom_range(0, FRAME_LEN - 1));
      @(negedge clk);
    end
    in_valid = 1'b0; in_sof = 1'b0; dec_done = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/turbo_frame_loader.md
# turbo_frame_loader

Parametrised ping-pong channel-symbol buffer between the receive datapath and `turbo_top`. It accepts one frame of `FRAME_LEN` soft-symbol words over a valid/ready stream and hands each complete frame to the decoder with a one-cycle active-low decoder reset. It then serves the decoder's random-address reads while the next frame fills the other bank. It replaces the fixed 263-word, counter-sequenced single-buffer loader in the decoder top level.

## Interface
Parameters:
- `DATA_W`, 48, soft-symbol word width per address
- `FRAME_LEN`, 263, words per frame
- `ADDR_W`, 9, address width; must satisfy 2^ADDR_W >= FRAME_LEN

Ports:
- `clk`  in  1  decoder clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_W  channel symbol word
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a word this cycle
- `in_sof`  in  1  qualifies the current word as word 0 of a frame
- `dec_rst`  out  1  active-low reset to `turbo_top`
- `dec_addr`  in  ADDR_W  decoder read address
- `dec_data`  out  DATA_W  registered read data
- `dec_done`  in  1  single-cycle pulse: decoder has finished the current frame
- `err_short`  out  1  single-cycle pulse: a frame was aborted by an early `in_sof`

## Operation
- Two banks, each `FRAME_LEN` x `DATA_W`. Each bank holds a 2-bit state: EMPTY, FILLING, FULL or DECODING.
- `wr_sel` selects the bank that is written. `rd_sel` selects the bank that is read.
- A write occurs when `in_valid && in_ready`. The word goes to `wr_sel` at `wr_addr`, and `wr_addr` increments.
- A write with `in_sof` forces `wr_addr` to 0 and sets the bank to FILLING.
- Words accepted while no frame is open are dropped, i.e. the bank is EMPTY and `in_sof` is low.
- Early `in_sof`: if `in_sof` arrives while the bank is FILLING and `wr_addr != 0`, the partial frame is discarded. The word is written at address 0, and `err_short` pulses.
- Frame complete: the write at `wr_addr == FRAME_LEN-1` sets the bank to FULL and `wr_addr` to 0.
  - If the other bank is EMPTY, `wr_sel` toggles.
  - Otherwise `in_ready` stays low until a bank frees.
- `in_ready` = the `wr_sel` bank is EMPTY or FILLING.
- Hand-off: occurs when a bank is FULL and no bank is DECODING. On that edge:
  - the bank becomes DECODING;
  - `rd_sel` points to it;
  - `dec_rst` is driven 0 for exactly one cycle, then 1.
- `dec_done` while a bank is DECODING sets that bank to EMPTY. If `wr_sel` was blocked on it, filling resumes there.
- `dec_done` with no bank DECODING is ignored.
- Simultaneous frame complete and `dec_done`: both take effect on the same edge. The hand-off of the newly FULL bank happens on the next edge.
- `dec_data` = `mem[rd_sel][dec_addr]`, registered. An out-of-range address returns an undefined value and has no side effect.

## Timing
- Reset values:
  - `in_ready` = 0 during reset, and 1 from the first edge after deassertion;
  - `dec_rst` = 0, held low until the first hand-off pulse completes;
  - `dec_data` = 0;
  - `err_short` = 0;
  - both banks EMPTY; `wr_sel` = `rd_sel` = 0; `wr_addr` = 0.
- Last word is written at edge t:
  - bank is FULL after t;
  - `dec_rst` is 0 during cycle t+1 when the decoder is idle;
  - `dec_rst` is 1 from t+2;
  - the first valid decoder address is presented in cycle t+2.
- Read latency is 1 cycle: `dec_addr` is sampled at edge n, and `dec_data` is valid after edge n.
- If `rst` is asserted mid-frame, all state is cleared asynchronously. Partial and FULL frames are lost, and `dec_rst` drops to 0 immediately.
- Sustained throughput is one word per cycle while decode time <= `FRAME_LEN` cycles.

## Configuration
- `TURBO_LOADER_PINGPONG_EN` defined: two banks, as described above.
- Undefined: one bank only.
  - `rd_sel` = `wr_sel` = 0.
  - `in_ready` is low from FULL through DECODING until `dec_done`.
  - Hand-off timing is identical.
  - Half the memory is used.

## Structure
- Shared package `turbo_pkg`: `DATA_W`, `FRAME_LEN` and `ADDR_W` defaults, plus the `bank_state_t` enum (EMPTY, FILLING, FULL, DECODING).
- One sub-module, `loader_bank`: synchronous write and registered read over `FRAME_LEN` x `DATA_W` distributed RAM. It is instantiated once or twice under the macro.
- The control FSM and read mux live in the top module.

## Test plan
- Reset, then one 263-word frame (word i = i) -> `dec_rst` low for exactly one cycle in cycle t+1. Reads of addresses 0, 131 and 262 return 0, 131 and 262 one cycle later.
- Two back-to-back frames with no `dec_done` -> frame 2 fills bank 1 and `in_ready` drops after its last word. `dec_done` -> hand-off pulse for bank 1 on the next edge, and `in_ready` returns to 1.
- `in_sof` at word 100 of a frame -> `err_short` pulses once. The frame completes 263 words after the new `in_sof`, and address 0 holds the new word.
- `dec_done` on the same edge as the last word of the next frame -> bank freed. Hand-off occurs exactly one edge later with no lost or duplicated `dec_rst` pulse.
- `rst` asserted at word 50 -> `in_ready` and `dec_rst` are 0 immediately. After release, a full frame loads and hands off normally.
- Macro undefined, two frames offered -> `in_ready` stays low from the first frame FULL until `dec_done`. Data read matches frame 1, then frame 2.
